uart_tx_buffered: RTL
=====================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLK_DIV, default 868, clock cycles per serial bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, 2..256.
REQ-003 Parameter PARITY_EN, default 0, 1 inserts a parity bit between data bit 7 and stop.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 wr_data  input  8  byte to enqueue.
REQ-008 wr_valid  input  1  enqueue request.
REQ-009 wr_ready  output  1  FIFO not full; a write is accepted when wr_valid and wr_ready are both high at a rising edge.
REQ-010 tx  output  1  serial line, always driven, idle high.
REQ-011 busy  output  1  high while the FSM is outside IDLE.
REQ-012 fifo_count  output  log2(FIFO_DEPTH)+1  bytes queued, not counting the byte being shifted.
REQ-013 tx_done  output  1  one-cycle pulse in the last cycle of each stop bit.

Function
REQ-014 Frame: start bit 0, data bits LSB first, optional parity bit, one stop bit 1; each bit held exactly CLK_DIV cycles.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is entered only when PARITY_EN=1.
REQ-016 IDLE -> START when the FIFO is non-empty: head popped and loaded into the shift register that same edge; tx falls at that edge.
REQ-017 Latency: a write accepted at edge E into an empty FIFO with the FSM in IDLE gives tx low after edge E+1.
REQ-018 START -> DATA, DATA (8 bits, 3-bit index) -> PARITY or STOP, PARITY -> STOP; each transition on bit-counter terminal count CLK_DIV-1, with the counter then reset to 0.
REQ-019 STOP terminal: FIFO non-empty -> pop and go to START with no idle gap; empty -> IDLE.
REQ-020 Parity bit is XOR of the 8 data bits, inverted when PARITY_ODD=1.
REQ-021 Same-edge push and pop: fifo_count unchanged, both take effect.
REQ-022 Full: wr_ready low; a write attempt has no effect; wr_ready rises the cycle after a pop.
REQ-023 Empty: no pop; fifo_count never underflows; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-024 wr_data is captured only at an accepting edge; later input changes do not alter queued bytes.
REQ-025 All outputs are registered or driven directly from registers; no combinational input-to-output path except wr_ready, which depends on FIFO state only.

Reset
REQ-026 When rst_n is low at an edge: FSM IDLE, tx=1, busy=0, tx_done=0, fifo_count=0, wr_ready=1, bit counter 0, FIFO pointers 0.
REQ-027 Reset mid-frame abandons the frame: tx is 1 after the reset edge, and queued bytes are discarded.
REQ-028 Writes presented during reset are not accepted.

Structure
REQ-029 Shared package uart_pkg holds the FSM state encoding, DEFAULT_CLK_DIV=868, and UART_DATA_BITS=8.
REQ-030 One sub-module, sync_fifo (parameterised width/depth, synchronous active-low reset, push/pop/full/empty/count), holds the queue; the FSM, bit counter, shift register and parity stay in uart_tx_buffered.

Verification
REQ-031 CLK_DIV=4, PARITY_EN=0, write 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles; tx low 1 cycle after the write edge; tx_done pulses in cycle 40 of the frame; busy falls after it.
REQ-032 CLK_DIV=4, 17 back-to-back writes on consecutive cycles -> the first byte pops immediately, then fifo_count=16 and wr_ready=0; the 18th write is ignored; 17 frames are sent contiguously with no idle cycle between stop and start.
REQ-033 PARITY_EN=1: write 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame is 11 bits.
REQ-034 Reset asserted mid-data-bit with 3 bytes queued -> after the reset edge tx=1, busy=0, fifo_count=0, and no further frames are sent.
REQ-035 Full FIFO, write and stop-bit-end pop on the same edge -> the write is rejected because wr_ready was low; fifo_count goes 16 -> 15; the next write is accepted.
REQ-036 Bench checks every frame with a reference receiver sampling mid-bit and compares against a byte scoreboard.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM state encoding, framing constants
// and the parity helper used when loading a byte.
package uart_pkg;

   localparam int unsigned DEFAULT_CLK_DIV = 868;
   localparam int unsigned UART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } tx_state_e;

   // Even parity is the XOR of the data bits; odd parity inverts it.
   function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data,
                                        input logic                      odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset. A push while full is
// dropped even if a pop happens on the same edge; a pop while empty is ignored.
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 16,
   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW  = $clog2(Depth) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wr_data,
   output logic [Width-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CntW-1:0]  count
);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CntW'(Depth));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Depth is a power of two, so pointer increments wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: 8N1 frames (optional parity), bit time CLK_DIV
// clocks, back-to-back frames whenever the queue holds data at the end of a stop bit.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          PARITY_ODD = 1'b0,
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [UART_DATA_BITS-1:0] wr_data,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   output logic                      tx,
   output logic                      busy,
   output logic [CntW-1:0]           fifo_count,
   output logic                      tx_done
);

   localparam int unsigned IdxW    = $clog2(UART_DATA_BITS);
   localparam logic [15:0] BitLast = 16'(CLK_DIV - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(UART_DATA_BITS - 1);

   tx_state_e                 state_q, state_d;
   logic [15:0]               bit_cnt_q, bit_cnt_d;
   logic [IdxW-1:0]           bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      parity_q, parity_d;
   logic                      tx_q, tx_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   logic                      fifo_pop, fifo_full, fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_rd_data;
   logic                      bit_end;

   sync_fifo #(
      .Width (UART_DATA_BITS),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (wr_valid),
      .pop     (fifo_pop),
      .wr_data (wr_data),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign wr_ready = ~fifo_full;
   assign bit_end  = (bit_cnt_q == BitLast);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      fifo_pop  = 1'b0;

      if (state_q != StIdle) bit_cnt_d = bit_end ? '0 : bit_cnt_q + 16'd1;

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shift_d   = fifo_rd_data;
               parity_d  = calc_parity(fifo_rd_data, PARITY_ODD);
               bit_cnt_d = '0;
               state_d   = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               bit_idx_d = '0;
               state_d   = StData;
            end
         end
         StData: begin
            // The LSB of the shift register is always the bit on the line.
            if (bit_end) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + IdxW'(1);
               if (bit_idx_q == IdxLast) state_d = PARITY_EN ? StParity : StStop;
            end
         end
         StParity: begin
            if (bit_end) state_d = StStop;
         end
         StStop: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  shift_d   = fifo_rd_data;
                  parity_d  = calc_parity(fifo_rd_data, PARITY_ODD);
                  state_d   = StStart;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so that they are registered.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = parity_d;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != StIdle);
      done_d = (state_d == StStop) && (bit_cnt_d == BitLast);
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign tx_done = done_q;

endmodule
